aes_core_arbiter: RTL
=====================

Name: aes_core_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer that shares one iterative AES-128 core.
- Accepts encrypt/decrypt jobs from two independent clients and latches each job's data, key and direction.
- Issues a one-cycle start to the core, waits for the core's done pulse, and returns the result to the owning requester.
- Sits between the host-side block producers and the single AES core instance.

Parameters:
- DATA_W, 128, width of data and key buses. Fixed at 128 for AES-128; other values are unsupported.
- INIT_PRIO, 0, requester that holds priority after reset (0 or 1).
- TIMEOUT_CYC, 64, BUSY-state cycle limit. Used only when AES_ARB_TIMEOUT_EN is defined.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous reset, active-low.
- i_fReq0  in  1  requester 0 job request, level.
- i_fDec0  in  1  requester 0 direction: 1 = decrypt, 0 = encrypt.
- i_Data0  in  128  requester 0 input block.
- i_Key0  in  128  requester 0 key.
- o_fAck0  out  1  one-cycle pulse: job 0 accepted and latched.
- o_fDone0  out  1  one-cycle pulse: o_Data holds job 0 result.
- i_fReq1, i_fDec1, i_Data1, i_Key1, o_fAck1, o_fDone1: same as requester 0, for requester 1.
- o_Data  out  128  result register, shared by both requesters.
- o_fBusy  out  1  high when state is not IDLE.
- o_fTimeout  out  1  one-cycle abort pulse (see Optional Feature).
- o_fCoreStart  out  1  one-cycle start pulse to the core.
- o_fCoreDec  out  1  direction to the core.
- o_CoreData  out  128  operand to the core.
- o_CoreKey  out  128  key to the core.
- i_CoreData  in  128  core result.
- i_fCoreDone  in  1  core done pulse.

Behaviour:
- Reset (Rst=0, asynchronous): all outputs 0, state IDLE, priority pointer = INIT_PRIO, owner register = 0, timeout counter = 0.
- All outputs are registered.
- States: IDLE, START, BUSY.
- IDLE:
  - At a clock edge with at least one request high, select the winner:
    - only one request high: that requester wins.
    - both high: the requester named by the priority pointer wins.
  - On selection: latch the winner's Dec/Data/Key into o_fCoreDec/o_CoreData/o_CoreKey, set owner, assert o_fAckN for one cycle, go to START.
  - No request: stay in IDLE; outputs hold.
- START:
  - o_fCoreStart=1 for exactly this cycle.
  - Go to BUSY at the next edge.
  - i_fCoreDone during START is ignored.
- BUSY:
  - Operand registers are held stable for the whole state.
  - At an edge with i_fCoreDone=1: o_Data <= i_CoreData, o_fDoneN=1 for one cycle (N = owner), priority pointer <= other requester, go to IDLE.
- Latency:
  - Request sampled at edge T: ack high in cycle T..T+1, start high in cycle T+1..T+2.
  - Done is asserted the cycle after the core's done pulse.
  - Minimum back-to-back spacing is 1 IDLE cycle.
- Requester rules:
  - Must drop its request in the cycle it sees ack. A request still high when the next arbitration occurs counts as a new job.
  - Must keep its inputs valid while its request is high. Inputs are not sampled after ack.
- Priority rotates only on job completion or abort, never on acceptance alone. A lone requester is served repeatedly without waiting.
- o_Data holds its last value until the next completion; it is not cleared on acceptance.
- i_fCoreDone while IDLE: ignored, no done pulse.
- Reset mid-job: the job is dropped silently and no done pulse is issued. The core is expected to be reset by the same Rst. A late core done after reset is ignored.

Optional Feature:
- Macro: AES_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If the count reaches TIMEOUT_CYC with no core done: o_fTimeout=1 for one cycle, no o_fDoneN, o_Data unchanged, priority rotates, state goes to IDLE.
  - A core done arriving in the same cycle the count reaches TIMEOUT_CYC wins; it is treated as normal completion.
- When undefined: no counter logic; o_fTimeout is tied to 0; BUSY waits indefinitely.

Test Plan:
- Req0 encrypt, Key 5468617473206D79204B756E67204675, Data 54776F204F6E65204E696E652054776F -> o_fAck0 for 1 cycle, o_fCoreStart for 1 cycle the next cycle with o_fCoreDec=0; o_fDone0 pulse with o_Data=29C3505F571420F6402299B31A02D73A; o_fDone1 stays 0.
- Req1 decrypt, same key, Data 29C3505F571420F6402299B31A02D73A -> o_fDone1 pulse with o_Data=54776F204F6E65204E696E652054776F.
- Req0 and Req1 raised in the same cycle after reset (INIT_PRIO=0) -> job 0 acked and completed first, then job 1 with no extra idle gap beyond 1 cycle; two further simultaneous requests -> job 0 first again (pointer back to 0).
- Rst driven low 5 cycles into BUSY -> o_fBusy, o_fCoreStart and all ack/done outputs are 0 immediately (asynchronous); a core done after Rst returns high produces no done pulse.
- i_fCoreDone pulsed while IDLE -> no o_fDone0/o_fDone1 pulse; o_Data unchanged.
- AES_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16, core never asserts done -> o_fTimeout pulse after 16 BUSY cycles, no done pulse, o_fBusy=0 the following cycle, and a pending req1 is served next.

Source files
------------

// File: rtl/aes_core_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | aes_core_arbiter_if                                                         |
// | Request/result and core-side signal bundle for aes_core_arbiter.            |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
interface aes_core_arbiter_if #(
    parameter int DATA_W = 128
);
    logic              i_fReq0;
    logic              i_fDec0;
    logic [DATA_W-1:0] i_Data0;
    logic [DATA_W-1:0] i_Key0;
    logic              o_fAck0;
    logic              o_fDone0;
    logic              i_fReq1;
    logic              i_fDec1;
    logic [DATA_W-1:0] i_Data1;
    logic [DATA_W-1:0] i_Key1;
    logic              o_fAck1;
    logic              o_fDone1;
    logic [DATA_W-1:0] o_Data;
    logic              o_fBusy;
    logic              o_fTimeout;
    logic              o_fCoreStart;
    logic              o_fCoreDec;
    logic [DATA_W-1:0] o_CoreData;
    logic [DATA_W-1:0] o_CoreKey;
    logic [DATA_W-1:0] i_CoreData;
    logic              i_fCoreDone;

    // Arbiter view
    modport slave (
        input  i_fReq0, i_fDec0, i_Data0, i_Key0,
        input  i_fReq1, i_fDec1, i_Data1, i_Key1,
        input  i_CoreData, i_fCoreDone,
        output o_fAck0, o_fDone0, o_fAck1, o_fDone1,
        output o_Data, o_fBusy, o_fTimeout,
        output o_fCoreStart, o_fCoreDec, o_CoreData, o_CoreKey
    );

    // Requesters plus AES core view
    modport master (
        output i_fReq0, i_fDec0, i_Data0, i_Key0,
        output i_fReq1, i_fDec1, i_Data1, i_Key1,
        output i_CoreData, i_fCoreDone,
        input  o_fAck0, o_fDone0, o_fAck1, o_fDone1,
        input  o_Data, o_fBusy, o_fTimeout,
        input  o_fCoreStart, o_fCoreDec, o_CoreData, o_CoreKey
    );
endinterface
`default_nettype wire

// File: rtl/aes_core_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | aes_core_arbiter                                                            |
// | Two-client round-robin sequencer sharing one iterative AES-128 core.        |
// | Optional BUSY watchdog: define AES_ARB_TIMEOUT_EN.                          |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
module aes_core_arbiter #(
    parameter int DATA_W      = 128,
    parameter int INIT_PRIO   = 0,
    parameter int TIMEOUT_CYC = 64
) (
    input  wire logic         Clk,
    input  wire logic         Rst,
    aes_core_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_prio;
    logic              r_owner;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_done0;
    logic              r_done1;
    logic              r_start;
    logic              r_busy;
    logic              r_dec;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_cdata;
    logic [DATA_W-1:0] r_ckey;

    logic              w_any;
    logic              w_win;

    if (DATA_W != 128 || INIT_PRIO < 0 || INIT_PRIO > 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("aes_core_arbiter: unsupported parameter value");
    end

    assign w_any = bus.i_fReq0 | bus.i_fReq1;
    // Contention resolved by the pointer; otherwise the lone requester wins.
    assign w_win = (bus.i_fReq0 & bus.i_fReq1) ? r_prio : bus.i_fReq1;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_tmo;
    logic               w_tmo_hit;

    assign w_tmo_hit      = (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYC - 1));
    assign bus.o_fTimeout = r_tmo;
`else
    assign bus.o_fTimeout = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state   <= S_IDLE;
            r_prio    <= (INIT_PRIO != 0);
            r_owner   <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_dec     <= 1'b0;
            r_data    <= '0;
            r_cdata   <= '0;
            r_ckey    <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
`endif
        end else begin
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_start <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
            r_tmo   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_win;
                        r_dec   <= w_win ? bus.i_fDec1 : bus.i_fDec0;
                        r_cdata <= w_win ? bus.i_Data1 : bus.i_Data0;
                        r_ckey  <= w_win ? bus.i_Key1  : bus.i_Key0;
                        r_ack0  <= ~w_win;
                        r_ack1  <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    // Start lands in the first BUSY cycle, one cycle after ack.
                    r_start   <= 1'b1;
                    r_state   <= S_BUSY;
`ifdef AES_ARB_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end
                S_BUSY: begin
                    if (bus.i_fCoreDone) begin
                        r_data  <= bus.i_CoreData;
                        r_done0 <= ~r_owner;
                        r_done1 <= r_owner;
                        r_prio  <= ~r_owner;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
`ifdef AES_ARB_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_tmo   <= 1'b1;
                        r_prio  <= ~r_owner;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_fAck0      = r_ack0;
    assign bus.o_fAck1      = r_ack1;
    assign bus.o_fDone0     = r_done0;
    assign bus.o_fDone1     = r_done1;
    assign bus.o_Data       = r_data;
    assign bus.o_fBusy      = r_busy;
    assign bus.o_fCoreStart = r_start;
    assign bus.o_fCoreDec   = r_dec;
    assign bus.o_CoreData   = r_cdata;
    assign bus.o_CoreKey    = r_ckey;

endmodule
`default_nettype wire
